// File: rtl/uop_sequencer.sv
// uop_sequencer
//   Streams a run of uops out of the 512x32 uop cache. A start request latches
//   an address and a length; the sequencer then issues sequential cache reads,
//   captures each returned uop one cycle later, and buffers it in a small FIFO.
//   The FIFO head is presented to decode/issue. The final uop of the run is
//   marked, and a one-cycle done pulse follows its acceptance.
//
//   Reads are only issued while the FIFO has room for the data already in
//   flight plus the new read. Because of this credit rule, the FIFO can never
//   overflow, and the return path needs no stall.
//
// Handshake: a uop transfers on a rising clk edge where uop_valid & uop_ready.
//   While uop_valid is high and uop_ready is low, uop_data and uop_last hold
//   stable. uop_valid never depends on uop_ready.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   start               1-cycle request, honoured only while idle
//   start_addr/len      first cache address / number of uops (0..512)
//   abort               cancel and flush everything; has priority over start
//   busy                sequence in progress (RUN or DRAIN)
//   done                1-cycle pulse when a sequence completes normally
//   cache_read_enable   read strobe to the cache
//   cache_read_address  read address to the cache
//   cache_instruction   cache read data, valid the cycle after the strobe
//   uop_valid/data/last FIFO head toward the consumer
//   uop_ready           consumer accepts the head
//   dbg_state           FSM state, for checkers (0 IDLE, 1 RUN, 2 DRAIN)
module uop_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              cache_read_enable,
  output logic [ADDR_W-1:0] cache_read_address,
  input  logic [DATA_W-1:0] cache_instruction,
  output logic              uop_valid,
  output logic [DATA_W-1:0] uop_data,
  output logic              uop_last,
  input  logic              uop_ready,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_inflight;
  logic               r_inflight_last;
  logic               r_done;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic               r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_head_last;
  logic               w_credit_ok;
  logic [CNT_W-1:0]   w_occupancy;
  logic               w_zero_len_start;

  // Count the read already in flight as an occupied slot. That slot is
  // reserved for the returning data.
  assign w_occupancy      = r_count + CNT_W'(r_inflight);
  assign w_credit_ok      = (w_occupancy < CNT_W'(FIFO_DEPTH));
  assign w_push           = r_inflight;
  assign w_pop            = uop_valid & uop_ready;
  assign w_head_last      = r_mem_last[r_rd_ptr];
  assign w_zero_len_start = (r_state == S_IDLE) && start && (start_len == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (start_len != '0)) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (r_remaining == LEN_W'(1)) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i]      <= '0;
        r_mem_last[i] <= 1'b0;
      end
    end else if (abort) begin
      // Flush. Clearing the in-flight flag drops the data of any read still
      // on its way back from the cache.
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else begin
      r_done          <= w_zero_len_start || (w_pop && w_head_last);
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == LEN_W'(1));

      if ((r_state == S_IDLE) && start) begin
        r_addr      <= start_addr;
        r_remaining <= start_len;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end

      if (w_push) begin
        r_mem[r_wr_ptr]      <= cache_instruction;
        r_mem_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy               = (r_state != S_IDLE);
  assign done               = r_done;
  assign cache_read_enable  = w_issue;
  assign cache_read_address = r_addr;
  assign uop_valid          = (r_count != '0);
  assign uop_data           = r_mem[r_rd_ptr];
  assign uop_last           = w_head_last & uop_valid;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer. A behavioural cache returns data_of(addr)
// one cycle after each read strobe. Inputs are driven on the falling edge, and
// outputs are sampled there too.
module tb_uop_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  start_addr;
  logic [9:0]  start_len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        cache_read_enable;
  logic [8:0]  cache_read_address;
  logic [31:0] cache_instruction;
  logic        uop_valid;
  logic [31:0] uop_data;
  logic        uop_last;
  logic        uop_ready;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  uop_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .start_addr         (start_addr),
    .start_len          (start_len),
    .abort              (abort),
    .busy               (busy),
    .done               (done),
    .cache_read_enable  (cache_read_enable),
    .cache_read_address (cache_read_address),
    .cache_instruction  (cache_instruction),
    .uop_valid          (uop_valid),
    .uop_data           (uop_data),
    .uop_last           (uop_last),
    .uop_ready          (uop_ready),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset / cache model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [8:0] a);
    return {7'h2D, a, 7'h33, a};
  endfunction

  initial cache_instruction = 32'd0;
  always @(posedge clk) begin
    if (cache_read_enable) cache_instruction <= data_of(cache_read_address);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Streams one sequence and checks read addresses, uop order, last tag, data
  // hold during stalls, and done timing against the expected queue.
  task automatic run_seq(input logic [8:0] addr, input logic [9:0] len,
                         input int stall, input bit rand_ready, input bit poke);
    logic [8:0]  exp_addr;
    logic [31:0] exp_d;
    logic [31:0] prev_data;
    bit          prev_stall;
    bit          done_seen;
    int          reads;
    int          pops;
    int          last_pop;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) exp_q.push_back(data_of(addr + 9'(i)));
    start = 1'b1; start_addr = addr; start_len = len; uop_ready = 1'b0;
    @(posedge clk);
    exp_addr = addr; reads = 0; pops = 0; last_pop = -100;
    done_seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int k = 1; k <= 400 && !done_seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; start_addr = 9'h100; start_len = 10'd3;
      end
      uop_ready = (k <= stall) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      if (cache_read_enable) begin
        check("rd_addr", 32'(cache_read_address), 32'(exp_addr));
        exp_addr = exp_addr + 9'd1;
        reads++;
      end
      if (k == stall) begin
        check("stall_reads", 32'(reads), 32'((len < 10'd4) ? int'(len) : 4));
        check("stall_re_low", 32'(cache_read_enable), 32'd0);
      end
      if (prev_stall) check("hold_data", uop_data, prev_data);
      if (uop_valid && uop_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_uop", 32'd1, 32'd0);
        end else begin
          exp_d = exp_q.pop_front();
          check("uop_data", uop_data, exp_d);
          check("uop_last", 32'(uop_last), 32'(exp_q.size() == 0));
        end
        pops++;
        last_pop = k;
      end
      prev_stall = uop_valid && !uop_ready;
      prev_data  = uop_data;
      if (done) begin
        done_seen = 1'b1;
        check("done_timing", 32'(k), 32'(last_pop + 1));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    uop_ready = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("uop_count", 32'(pops), 32'(len));
    check("read_count", 32'(reads), 32'(len));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int reads;
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; start_addr = '0; start_len = '0;
    abort = 1'b0; uop_ready = 1'b0;
    idle_cycles(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_re", 32'(cache_read_enable), 32'd0);
    check("rst_valid", 32'(uop_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    // addr 0x010 len 4, consumer always ready: exact cycle trace
    start = 1'b1; start_addr = 9'h010; start_len = 10'd4; uop_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("t4_re", 32'(cache_read_enable), 32'(k >= 1 && k <= 4));
      if (k <= 4) check("t4_addr", 32'(cache_read_address), 32'(9'h010 + 9'(k - 1)));
      check("t4_valid", 32'(uop_valid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check("t4_data", uop_data, data_of(9'h010 + 9'(k - 3)));
      check("t4_last", 32'(uop_last), 32'(k == 6));
      check("t4_done", 32'(done), 32'(k == 7));
      check("t4_busy", 32'(busy), 32'(k <= 6));
    end
    uop_ready = 1'b0;
    idle_cycles(2);

    // address wrap 0x1FE -> 0x001
    run_seq(9'h1FE, 10'd4, 0, 1'b0, 1'b0);
    idle_cycles(2);
    // credit stall: 16 uops, consumer stalled for 10 cycles
    run_seq(9'h020, 10'd16, 10, 1'b0, 1'b0);
    idle_cycles(2);
    // random back-pressure plus a start while busy that must be ignored
    run_seq(9'h150, 10'd12, 0, 1'b1, 1'b1);
    idle_cycles(2);

    // zero length: done next cycle, no reads
    start = 1'b1; start_addr = 9'h005; start_len = 10'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("z_done", 32'(done), 32'd1);
    check("z_re", 32'(cache_read_enable), 32'd0);
    check("z_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("z_done_once", 32'(done), 32'd0);
    check("z_re2", 32'(cache_read_enable), 32'd0);
    idle_cycles(2);

    // abort the cycle after the 3rd read of len 8
    start = 1'b1; start_addr = 9'h040; start_len = 10'd8; uop_ready = 1'b0;
    @(posedge clk);
    reads = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 3 && cache_read_enable) reads++;
      if (k == 4) abort = 1'b1;
    end
    check("ab_reads", 32'(reads), 32'd3);
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_valid", 32'(uop_valid), 32'd0);
    check("ab_re", 32'(cache_read_enable), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ab_no_push", 32'(uop_valid), 32'd0);
      check("ab_no_done", 32'(done), 32'd0);
    end
    idle_cycles(2);

    // asynchronous reset in the middle of RUN
    start = 1'b1; start_addr = 9'h080; start_len = 10'd8; uop_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_re", 32'(cache_read_enable), 32'd0);
    check("mr_valid", 32'(uop_valid), 32'd0);
    check("mr_data", uop_data, 32'd0);
    check("mr_last", 32'(uop_last), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mr_no_read", 32'(cache_read_enable), 32'd0);
      check("mr_idle", 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
